// File: rtl/router_fifo_if.sv
// rtl/router_fifo_if.sv - write/read handshake bundle between router FSM, register stage, destination and output FIFO
interface router_fifo_if #(
    parameter int WIDTH = 8
);
    logic             soft_reset;
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             pkt_done;

    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty, pkt_done
    );

    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty, pkt_done
    );
endinterface

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-port output FIFO of the 1x3 router with header-flagged entries and packet-done pulse
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           rstn,
    router_fifo_if.slave   bus
);
    localparam int CW = WIDTH - 2;

    logic [WIDTH:0]   mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             pkt_done_q, pkt_done_d;
    logic             full_w, empty_w;
    logic             wr_fire, rd_fire;
    logic [WIDTH:0]   rd_entry;

    assign empty_w  = (wr_ptr_q == rd_ptr_q);
    assign full_w   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_fire  = bus.write_enb && !full_w && !bus.soft_reset;
    assign rd_fire  = bus.read_enb && !empty_w && !bus.soft_reset;
    assign rd_entry = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        pkt_done_d = 1'b0;
        if (bus.soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                data_out_d = rd_entry[WIDTH-1:0];
                // Header length field counts payload only; +1 accounts for the parity byte
                if (rd_entry[WIDTH]) begin
                    pkt_cnt_d = rd_entry[WIDTH-1:2] + 1'b1;
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d  = pkt_cnt_q - 1'b1;
                    pkt_done_d = (pkt_cnt_q == {{(CW-1){1'b0}}, 1'b1});
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    // Storage is left unreset; only pointers define valid contents
    always_ff @(posedge clk) begin
        if (rstn && wr_fire) begin
            mem[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.pkt_done = pkt_done_q;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - directed scoreboard bench for router_fifo
module tb_router_fifo;
    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   failures = 0;

    logic [8:0] sb_q[$];
    logic [7:0] exp_dout;
    logic       exp_done;
    logic [5:0] exp_cnt;
    logic [4:0] exp_wr;

    router_fifo_if #(.WIDTH(8)) bus ();

    router_fifo #(.DEPTH(16), .WIDTH(8), .AW(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        exp_dout = 8'h00;
        exp_done = 1'b0;
        exp_cnt  = 6'd0;
        exp_wr   = 5'd0;
    endtask

    task automatic step(input logic we, input logic re, input logic lfd,
                        input logic sr, input logic [7:0] din);
        logic       m_full;
        logic       m_empty;
        logic [8:0] ent;
        bus.write_enb  = we;
        bus.read_enb   = re;
        bus.lfd_state  = lfd;
        bus.soft_reset = sr;
        bus.data_in    = din;
        m_full   = (sb_q.size() == 16);
        m_empty  = (sb_q.size() == 0);
        exp_done = 1'b0;
        if (sr) begin
            model_clear();
        end else begin
            if (re && !m_empty) begin
                ent      = sb_q.pop_front();
                exp_dout = ent[7:0];
                if (ent[8]) begin
                    exp_cnt = ent[7:2] + 6'd1;
                end else if (exp_cnt != 6'd0) begin
                    exp_done = (exp_cnt == 6'd1);
                    exp_cnt  = exp_cnt - 6'd1;
                end
            end
            if (we && !m_full) begin
                sb_q.push_back({lfd, din});
                exp_wr = exp_wr + 5'd1;
            end
        end
        @(posedge clk);
        #1;
        chk("data_out", 32'(bus.data_out), 32'(exp_dout));
        chk("pkt_done", 32'(bus.pkt_done), 32'(exp_done));
        chk("full",     32'(bus.full),     32'(sb_q.size() == 16));
        chk("empty",    32'(bus.empty),    32'(sb_q.size() == 0));
    endtask

    task automatic wr(input logic lfd, input logic [7:0] d);
        step(1'b1, 1'b0, lfd, 1'b0, d);
    endtask

    task automatic rd();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] saved;
        rstn = 1'b0;
        bus.soft_reset = 1'b0;
        bus.write_enb  = 1'b0;
        bus.read_enb   = 1'b0;
        bus.lfd_state  = 1'b0;
        bus.data_in    = 8'h00;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_pkt_done", 32'(bus.pkt_done), 32'd0);
        rstn = 1'b1;

        // Basic packet: header len=3, three payload bytes, parity
        wr(1'b1, 8'h0D);
        wr(1'b0, 8'hA1);
        wr(1'b0, 8'hA2);
        wr(1'b0, 8'hA3);
        wr(1'b0, 8'h5E);
        for (int i = 0; i < 5; i++) rd();
        chk("pkt1_done_seen", 32'(exp_done), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Fill to full, overflow write dropped
        for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h30 + i));
        chk("full_wr_ptr", 32'(dut.wr_ptr_q), 32'(exp_wr));
        wr(1'b0, 8'hEE);
        chk("overflow_wr_ptr", 32'(dut.wr_ptr_q), 32'(exp_wr));
        for (int i = 0; i < 16; i++) rd();

        // Fill to 15 and drain, three times across pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 15; i++) wr(1'b0, 8'($urandom_range(0, 255)));
            for (int i = 0; i < 15; i++) rd();
        end

        // Full with simultaneous read and write
        for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h70 + i));
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hCC);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 15; i++) rd();

        // Half a packet flushed by soft_reset
        wr(1'b1, 8'h0D);
        wr(1'b0, 8'hB1);
        rd();
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("sr_pkt_cnt", 32'(dut.pkt_cnt_q), 32'd0);
        wr(1'b1, 8'h0D);
        wr(1'b0, 8'hC1);
        wr(1'b0, 8'hC2);
        wr(1'b0, 8'hC3);
        wr(1'b0, 8'h9A);
        for (int i = 0; i < 5; i++) rd();
        chk("pkt2_done_seen", 32'(exp_done), 32'd1);

        // Zero-length packet, then read while empty
        wr(1'b1, 8'h00);
        wr(1'b0, 8'h77);
        rd();
        rd();
        chk("pkt0_done_seen", 32'(exp_done), 32'd1);
        saved = bus.data_out;
        rd();
        chk("empty_read_hold", 32'(bus.data_out), 32'(8'h77));
        chk("empty_read_same", 32'(bus.data_out), 32'(saved));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
